// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding controller.
// The operand select encodings, the FSM states and the tracker slot layout all live here.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned PC_IDX = 15;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EX  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             rf;
    logic             load;
    logic [REG_W-1:0] rd;
  } slot_t;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage bundle between the decode logic (master) and the hazard controller (slave).
// Hold travels with the bundle because it gates every control output.
interface hazard_forward_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic             Hold;
  logic [REG_W-1:0] Rn_ID;
  logic [REG_W-1:0] Rm_ID;
  logic [REG_W-1:0] Rd_ID;
  logic             UseA_ID;
  logic             UseB_ID;
  logic             UseC_ID;
  logic             rf_ID;
  logic             Load_ID;
  logic             BrTaken_ID;

  logic             PC_LE;
  logic             IFID_LE;
  logic             IFID_CLR;
  logic             NOP_Sel;
  fwd_sel_t         FwdA;
  fwd_sel_t         FwdB;
  fwd_sel_t         FwdC;

  modport master (
    output Hold, Rn_ID, Rm_ID, Rd_ID, UseA_ID, UseB_ID, UseC_ID, rf_ID, Load_ID, BrTaken_ID,
    input  PC_LE, IFID_LE, IFID_CLR, NOP_Sel, FwdA, FwdB, FwdC
  );

  modport slave (
    input  Hold, Rn_ID, Rm_ID, Rd_ID, UseA_ID, UseB_ID, UseC_ID, rf_ID, Load_ID, BrTaken_ID,
    output PC_LE, IFID_LE, IFID_CLR, NOP_Sel, FwdA, FwdB, FwdC
  );

endinterface

// File: rtl/fwd_select.sv
// Per-port priority matcher: picks the youngest in-flight producer of a source register.
// A load sitting in EX cannot supply data yet, so it only raises ex_load_hit.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_port,
  input  slot_t            ex,
  input  slot_t            mem,
  input  slot_t            wb,
  output fwd_sel_t         sel,
  output logic             ex_load_hit
);

  logic src_ok;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic unused_load;

  assign src_ok  = use_port && (src != REG_W'(PC_IDX));
  assign hit_ex  = src_ok && ex.valid  && ex.rf  && (ex.rd  == src);
  assign hit_mem = src_ok && mem.valid && mem.rf && (mem.rd == src);
  assign hit_wb  = src_ok && wb.valid  && wb.rf  && (wb.rd  == src);

  assign ex_load_hit = hit_ex && ex.load;
  assign unused_load = mem.load ^ wb.load;

  always_comb begin
    sel = FWD_RF;
    if (hit_ex && !ex.load) begin
      sel = FWD_EX;
    end else if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ID->EX hazard controller: tracks EX/MEM/WB destinations, drives operand forwarding,
// inserts a one-cycle bubble on load-use and flushes IF/ID on a taken branch.
module hazard_forward_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 CLR,
  hazard_forward_ctrl_if.slave bus
);

  slot_t    ex_q;
  slot_t    mem_q;
  slot_t    wb_q;
  state_e   state_q;

  logic [2:0] ex_load_hit;
  fwd_sel_t   fwd_a;
  fwd_sel_t   fwd_b;
  fwd_sel_t   fwd_c;
  logic       load_use;
  logic       stall;

  fwd_select u_fwd_a (
    .src         (bus.Rn_ID),
    .use_port    (bus.UseA_ID),
    .ex          (ex_q),
    .mem         (mem_q),
    .wb          (wb_q),
    .sel         (fwd_a),
    .ex_load_hit (ex_load_hit[0])
  );

  fwd_select u_fwd_b (
    .src         (bus.Rm_ID),
    .use_port    (bus.UseB_ID),
    .ex          (ex_q),
    .mem         (mem_q),
    .wb          (wb_q),
    .sel         (fwd_b),
    .ex_load_hit (ex_load_hit[1])
  );

  fwd_select u_fwd_c (
    .src         (bus.Rd_ID),
    .use_port    (bus.UseC_ID),
    .ex          (ex_q),
    .mem         (mem_q),
    .wb          (wb_q),
    .sel         (fwd_c),
    .ex_load_hit (ex_load_hit[2])
  );

  assign load_use = |ex_load_hit;
  // The stall is raised in the detection cycle itself, only from RUN.
  assign stall    = (state_q == RUN) && load_use;

  assign bus.FwdA     = fwd_a;
  assign bus.FwdB     = fwd_b;
  assign bus.FwdC     = fwd_c;
  assign bus.PC_LE    = !bus.Hold && !stall;
  assign bus.IFID_LE  = !bus.Hold && !stall;
  assign bus.NOP_Sel  = !bus.Hold && stall;
  assign bus.IFID_CLR = bus.BrTaken_ID && !load_use && !bus.Hold;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
    end else if (!bus.Hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bus.NOP_Sel) begin
        ex_q <= '0;
      end else begin
        ex_q <= slot_t'{valid: 1'b1, rf: bus.rf_ID, load: bus.Load_ID, rd: bus.Rd_ID};
      end
      unique case (state_q)
        RUN:     if (load_use) state_q <= STALL;
        STALL:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios with hand-derived expectations,
// then random traffic checked against a small reference model through an expectation queue.
module tb_hazard_forward_ctrl;
  import pipe_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  hazard_forward_ctrl_if bus ();

  hazard_forward_ctrl dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] rn;
    logic       ua;
    logic [3:0] rm;
    logic       ub;
    logic [3:0] rd;
    logic       uc;
    logic       rf;
    logic       ld;
    logic       br;
    logic       hold;
    logic       rst;
  } id_t;

  typedef struct packed {
    logic       pc_le;
    logic       ifid_le;
    logic       ifid_clr;
    logic       nop_sel;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] fc;
  } exp_t;

  typedef struct {
    bit         valid;
    bit         rf;
    bit         ld;
    logic [3:0] rd;
  } mslot_t;

  mslot_t m_slot[3];
  bit     m_stalled;
  bit     m_lu;
  bit     m_nop;
  exp_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic id_t mk(logic [3:0] rn, bit ua, logic [3:0] rm, bit ub, logic [3:0] rd,
                             bit uc, bit rf, bit ld, bit br, bit hold = 0, bit rst = 0);
    id_t r;
    r = '{rn: rn, ua: ua, rm: rm, ub: ub, rd: rd, uc: uc, rf: rf, ld: ld, br: br,
          hold: hold, rst: rst};
    return r;
  endfunction

  // Expectation with Hold low.
  function automatic exp_t xp(bit stall, bit clr, logic [1:0] fa, logic [1:0] fb,
                              logic [1:0] fc);
    exp_t e;
    e = '{pc_le: !stall, ifid_le: !stall, ifid_clr: clr, nop_sel: stall, fa: fa, fb: fb, fc: fc};
    return e;
  endfunction

  function automatic exp_t xh(logic [1:0] fa, logic [1:0] fb, logic [1:0] fc);
    exp_t e;
    e = '{pc_le: 0, ifid_le: 0, ifid_clr: 0, nop_sel: 0, fa: fa, fb: fb, fc: fc};
    return e;
  endfunction

  // Walk oldest to youngest so a younger producer overrides; an EX load only flags the hazard.
  function automatic logic [1:0] ref_sel(logic [3:0] src, bit u, output bit ldhit);
    logic [1:0] s;
    s     = 2'b00;
    ldhit = 0;
    for (int i = 2; i >= 0; i--) begin
      if (u && m_slot[i].valid && m_slot[i].rf && m_slot[i].rd == src && src != 4'd15) begin
        if (i == 0 && m_slot[i].ld) ldhit = 1;
        else s = 2'(i + 1);
      end
    end
    return s;
  endfunction

  function automatic exp_t model_eval(id_t in);
    exp_t e;
    bit   ha, hb, hc, stall;
    e.fa     = ref_sel(in.rn, in.ua, ha);
    e.fb     = ref_sel(in.rm, in.ub, hb);
    e.fc     = ref_sel(in.rd, in.uc, hc);
    m_lu     = ha || hb || hc;
    stall    = !m_stalled && m_lu;
    m_nop    = !in.hold && stall;
    e.pc_le    = !in.hold && !stall;
    e.ifid_le  = !in.hold && !stall;
    e.nop_sel  = m_nop;
    e.ifid_clr = in.br && !m_lu && !in.hold;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_slot[i] = '{valid: 0, rf: 0, ld: 0, rd: 4'd0};
    m_stalled = 0;
  endtask

  task automatic model_commit(input id_t in);
    if (!in.rst && !in.hold) begin
      m_slot[2] = m_slot[1];
      m_slot[1] = m_slot[0];
      if (m_nop) m_slot[0] = '{valid: 0, rf: 0, ld: 0, rd: 4'd0};
      else m_slot[0] = '{valid: 1, rf: in.rf, ld: in.ld, rd: in.rd};
      if (m_stalled) m_stalled = 0;
      else if (m_lu) m_stalled = 1;
    end
  endtask

  // One ID cycle: drive after the falling edge, sample 2 ns later, commit for the next rise.
  task automatic step(input string name, input id_t in, input bit hand, input exp_t hexp);
    exp_t e;
    @(negedge CLK);
    CLR            = !in.rst;
    bus.Hold       = in.hold;
    bus.Rn_ID      = in.rn;
    bus.Rm_ID      = in.rm;
    bus.Rd_ID      = in.rd;
    bus.UseA_ID    = in.ua;
    bus.UseB_ID    = in.ub;
    bus.UseC_ID    = in.uc;
    bus.rf_ID      = in.rf;
    bus.Load_ID    = in.ld;
    bus.BrTaken_ID = in.br;
    if (in.rst) model_reset();
    e = model_eval(in);
    exp_q.push_back(hand ? hexp : e);
    #2;
    e = exp_q.pop_front();
    check_eq({name, ".pc_le"},    8'(bus.PC_LE),    8'(e.pc_le));
    check_eq({name, ".ifid_le"},  8'(bus.IFID_LE),  8'(e.ifid_le));
    check_eq({name, ".ifid_clr"}, 8'(bus.IFID_CLR), 8'(e.ifid_clr));
    check_eq({name, ".nop_sel"},  8'(bus.NOP_Sel),  8'(e.nop_sel));
    check_eq({name, ".fwd_a"},    8'(bus.FwdA),     8'(e.fa));
    check_eq({name, ".fwd_b"},    8'(bus.FwdB),     8'(e.fb));
    check_eq({name, ".fwd_c"},    8'(bus.FwdC),     8'(e.fc));
    model_commit(in);
  endtask

  function automatic logic [3:0] rreg();
    if ($urandom_range(0, 9) == 0) return 4'd15;
    return 4'($urandom_range(0, 5));
  endfunction

  initial begin
    exp_t z;
    id_t  r;
    z = xp(0, 0, 0, 0, 0);
    bus.Hold = 0; bus.Rn_ID = 0; bus.Rm_ID = 0; bus.Rd_ID = 0;
    bus.UseA_ID = 0; bus.UseB_ID = 0; bus.UseC_ID = 0;
    bus.rf_ID = 0; bus.Load_ID = 0; bus.BrTaken_ID = 0;
    model_reset();

    step("reset",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, z);
    step("add_r1",      mk(2, 1, 3, 1, 1, 0, 1, 0, 0), 1, z);
    step("sub_fwd_ex",  mk(1, 1, 3, 1, 2, 0, 1, 0, 0), 1, xp(0, 0, 1, 0, 0));
    step("ldr_r4",      mk(0, 1, 0, 0, 4, 0, 1, 1, 0), 1, z);
    step("lu_stall",    mk(4, 1, 6, 1, 5, 0, 1, 0, 0), 1, xp(1, 0, 0, 0, 0));
    step("lu_fwd_mem",  mk(4, 1, 6, 1, 5, 0, 1, 0, 0), 1, xp(0, 0, 2, 0, 0));
    step("wr_r7_a",     mk(0, 0, 0, 0, 7, 0, 1, 0, 0), 1, z);
    step("wr_r8",       mk(0, 0, 0, 0, 8, 0, 1, 0, 0), 1, z);
    step("wr_r7_b",     mk(0, 0, 0, 0, 7, 0, 1, 0, 0), 1, z);
    step("ex_wins",     mk(5, 1, 7, 1, 8, 1, 0, 0, 0), 1, xp(0, 0, 0, 1, 2));
    step("wr_r15",      mk(0, 0, 0, 0, 15, 0, 1, 0, 0), 1, z);
    step("pc_no_fwd",   mk(15, 1, 7, 1, 3, 0, 1, 0, 0), 1, xp(0, 0, 0, 3, 0));
    step("use_gate",    mk(3, 0, 15, 1, 3, 1, 0, 0, 0), 1, xp(0, 0, 0, 0, 1));
    step("ldr_r10",     mk(0, 0, 0, 0, 10, 0, 1, 1, 0), 1, z);
    step("lu_br",       mk(10, 1, 0, 0, 0, 0, 0, 0, 1), 1, xp(1, 0, 0, 0, 0));
    step("hold_stall",  mk(10, 1, 0, 0, 0, 0, 0, 0, 1, 1), 1, xh(2, 0, 0));
    step("hold_stall2", mk(10, 1, 0, 0, 0, 0, 0, 0, 1, 1), 1, xh(2, 0, 0));
    step("br_flush",    mk(10, 1, 0, 0, 0, 0, 0, 0, 1), 1, xp(0, 1, 2, 0, 0));
    step("flushed",     mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, z);
    step("ldr_r11",     mk(0, 0, 0, 0, 11, 0, 1, 1, 0), 1, z);
    step("lu_r11",      mk(11, 1, 0, 0, 0, 0, 0, 0, 0), 1, xp(1, 0, 0, 0, 0));
    step("rst_mid",     mk(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1, z);
    step("post_rst",    mk(11, 1, 0, 0, 0, 0, 0, 0, 0), 1, z);

    for (int n = 0; n < 400; n++) begin
      r = mk(rreg(), 1'($urandom_range(0, 1)), rreg(), 1'($urandom_range(0, 1)), rreg(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
      step("rnd", r, 0, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard controller for the ID→EX boundary. It tracks the destination register of every instruction in flight in EX, MEM and WB, and drives the ID-stage operand forwarding selects for ports A, B and C. It detects load-use hazards and sequences a one-cycle stall: PC and IF/ID are frozen and a bubble is inserted into IDEX_Register. It also flushes IF/ID on a taken branch resolved in ID. It sits beside the ID stage and controls PC, IFID_Register and the control-signal NOP mux in front of IDEX_Register.

## Interface
- `REG_W`, 4: register-index width.
- `PC_IDX`, 15: register index that is never forwarded (the PC).
- `CLK` in 1: clock, rising edge.
- `CLR` in 1: reset, asynchronous and active-low (asserted at 0).
- `Hold` in 1: global pipeline freeze (memory not ready). The tracker and FSM hold their state.
- `Rn_ID`, `Rm_ID`, `Rd_ID` in 4 each: ID source indices for ports A, B and C.
- `UseA_ID`, `UseB_ID`, `UseC_ID` in 1 each: the ID instruction actually reads that port.
- `rf_ID` in 1: the ID instruction writes `Rd_ID`.
- `Load_ID` in 1: the ID instruction is a load.
- `BrTaken_ID` in 1: branch resolved taken in ID.
- `PC_LE` out 1: PC load enable.
- `IFID_LE` out 1: IF/ID load enable.
- `IFID_CLR` out 1: synchronous flush of IF/ID.
- `NOP_Sel` out 1: the IDEX control-input mux selects all-zero controls (bubble).
- `FwdA`, `FwdB`, `FwdC` out 2 each: operand source. 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.

## Operation
- Tracker: three slots, EX, MEM and WB, each holding {valid, rf, load, Rd}.
  - Each non-Hold edge: WB←MEM, MEM←EX.
  - EX←{1, rf_ID, Load_ID, Rd_ID}, or an invalid bubble when NOP_Sel=1.
  - Hold=1 leaves all slots unchanged.
- Match(port, slot) = Use_port & slot.valid & slot.rf & (slot.Rd == src) & (src != PC_IDX).
- Forwarding, per port, with priority EX > MEM > WB > regfile:
  - An EX match with EX.load=1 does not forward from EX; it raises the load-use hazard instead.
  - In that case the select falls through to a MEM or WB match, and is otherwise 00. This only matters for the stall cycle's don't-care operands.
- LoadUse = any port matches the EX slot while EX.load=1.
- FSM:
  - RUN: if LoadUse and !Hold → STALL.
  - STALL: if !Hold → RUN. A second back-to-back stall is not possible because the load has advanced to MEM.
- Outputs while the FSM is in RUN with LoadUse=1: PC_LE=0, IFID_LE=0, NOP_Sel=1. The stall is asserted combinationally in the cycle the hazard is detected.
- In STALL, outputs are normal and forwarding selects MEM (10) for the load.
- Branch: IFID_CLR = BrTaken_ID & !LoadUse & !Hold. During a load-use stall the branch is ignored; it is re-evaluated with forwarded operands next cycle.
- Hold=1 forces PC_LE=0, IFID_LE=0, NOP_Sel=0 and IFID_CLR=0. Forwarding selects stay valid.
- Reset (CLR=0), asynchronous:
  - All slots invalid, FSM=RUN.
  - Outputs: PC_LE=1, IFID_LE=1, IFID_CLR=0, NOP_Sel=0, Fwd*=00.
- Reset asserted mid-stall aborts the stall; the first cycle after release is RUN with an empty tracker.

## Timing
- Forwarding selects and stall controls are combinational from the ID inputs plus registered state. They are valid in the same cycle as the ID inputs.
- Load-use costs exactly one bubble cycle. The dependent instruction enters EX one cycle late and uses Fwd=10.
- A taken branch costs one flushed IF/ID slot. IFID_CLR is high for one cycle.
- Tracker slots are updated on the rising CLK edge when Hold=0.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - FWD_RF, FWD_EX, FWD_MEM, FWD_WB encodings.
  - FSM state constants RUN and STALL.
  - PC_IDX.
- One sub-module, `fwd_select`: a per-port priority matcher, instantiated three times (A, B, C). It takes the source index, the use flag and the three slots, and outputs the select plus an EX-load-hit flag.

## Test plan
- ADD R1 then SUB R2,R1,R3 back-to-back → FwdA=01 in the SUB ID cycle; no stall.
- LDR R4 then ADD R5,R4,R6 → cycle n: PC_LE=0, IFID_LE=0, NOP_Sel=1; cycle n+1: FwdA=10, no stall, EX slot invalid.
- R7 written by instructions in EX and WB, read by ID on port B → FwdB=01 (EX wins).
- Source R15 while EX writes R15 → FwdA=00. Source R3 with UseA=0 matching EX → FwdA=00.
- LoadUse and BrTaken_ID in the same cycle → IFID_CLR=0 and a stall. Next cycle BrTaken_ID=1 → IFID_CLR=1.
- Assert Hold during STALL → state and slots frozen, PC_LE=0. Drop CLR mid-stall → outputs at reset values immediately; post-release Fwd*=00.
